// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and reset values for the external-memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } arb_state_e;

   typedef enum logic {
      REQ_WR = 1'b0,
      REQ_RD = 1'b1
   } req_id_e;

   localparam arb_state_e STATE_RST    = IDLE;
   localparam req_id_e    LAST_SRV_RST = REQ_RD;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes plus the memory-side port of the arbiter.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_last;
   logic              wr_gnt;

   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_last;
   logic              rd_gnt;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;

   logic [ADDR_W-1:0] mem_WR_addr;
   logic              mem_write_flag;
   logic [DATA_W-1:0] mem_HWDATA;
   logic [ADDR_W-1:0] mem_RD_addr;
   logic              mem_read_flag;
   logic [DATA_W-1:0] mem_HRDATA;

   logic              busy;

   modport slave (
      input  wr_req, wr_addr, wr_data, wr_last,
      output wr_gnt,
      input  rd_req, rd_addr, rd_last,
      output rd_gnt, rd_data, rd_valid,
      output mem_WR_addr, mem_write_flag, mem_HWDATA,
      output mem_RD_addr, mem_read_flag,
      input  mem_HRDATA,
      output busy
   );

   modport master (
      output wr_req, wr_addr, wr_data, wr_last,
      input  wr_gnt,
      output rd_req, rd_addr, rd_last,
      input  rd_gnt, rd_data, rd_valid,
      input  mem_WR_addr, mem_write_flag, mem_HWDATA,
      input  mem_RD_addr, mem_read_flag,
      output mem_HRDATA,
      input  busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Grants whole write/read bursts on the single external-memory port with
// fair rotation and a per-tenure beat limit; memory strobes are registered.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_HOLD = 16
) (
   input logic               HCLK,
   input logic               HRESETn,
   mem_port_arbiter_if.slave bus
);

   localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

   arb_state_e        state, state_nxt;
   req_id_e           last_srv, last_srv_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;

   logic              wr_acc, rd_acc, at_limit;

   logic              wr_flag_q, rd_flag_q, rd_valid_q;
   logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
   logic [DATA_W-1:0] wr_data_q, rd_data_q;

   // A beat is accepted on any edge where the owner's request meets its grant.
   assign wr_acc   = (state == WR) && bus.wr_req;
   assign rd_acc   = (state == RD) && bus.rd_req;
   assign at_limit = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

   assign bus.wr_gnt = wr_acc;
   assign bus.rd_gnt = rd_acc;
   assign bus.busy   = (state != IDLE);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state    <= STATE_RST;
         last_srv <= LAST_SRV_RST;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         last_srv <= last_srv_nxt;
         hold_cnt <= hold_cnt_nxt;
      end
   end

   // Tenure ends on a last beat, the hold limit, or the owner dropping its request.
   always_comb begin
      state_nxt    = state;
      last_srv_nxt = last_srv;
      hold_cnt_nxt = hold_cnt;
      case (state)
         IDLE: begin
            if (bus.wr_req && (!bus.rd_req || (last_srv == REQ_RD))) begin
               state_nxt = WR;
            end else if (bus.rd_req) begin
               state_nxt = RD;
            end
         end
         WR: begin
            if (!bus.wr_req || bus.wr_last || at_limit) begin
               state_nxt    = bus.rd_req ? RD : IDLE;
               last_srv_nxt = REQ_WR;
            end else begin
               hold_cnt_nxt = hold_cnt + 1'b1;
            end
         end
         RD: begin
            if (!bus.rd_req || bus.rd_last || at_limit) begin
               state_nxt    = bus.wr_req ? WR : IDLE;
               last_srv_nxt = REQ_RD;
            end else begin
               hold_cnt_nxt = hold_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (state_nxt != state) begin
         hold_cnt_nxt = '0;
      end
   end

   // Memory-side strobes follow acceptance order; read data lands one cycle after its strobe.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_flag_q  <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         rd_flag_q  <= 1'b0;
         rd_addr_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         wr_flag_q  <= wr_acc;
         rd_flag_q  <= rd_acc;
         rd_valid_q <= rd_flag_q;
         if (wr_acc) begin
            wr_addr_q <= bus.wr_addr;
            wr_data_q <= bus.wr_data;
         end
         if (rd_acc) begin
            rd_addr_q <= bus.rd_addr;
         end
         if (rd_flag_q) begin
            rd_data_q <= bus.mem_HRDATA;
         end
      end
   end

   assign bus.mem_write_flag = wr_flag_q;
   assign bus.mem_WR_addr    = wr_addr_q;
   assign bus.mem_HWDATA     = wr_data_q;
   assign bus.mem_read_flag  = rd_flag_q;
   assign bus.mem_RD_addr    = rd_addr_q;
   assign bus.rd_valid       = rd_valid_q;
   assign bus.rd_data        = rd_data_q;

endmodule
